// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the nibble-serial subtract controller.
package serial_sub_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_sub_slice.sv
// One 4-bit subtract slice: sum = a_nib + ~b_nib + cin, with carry out.
module nibble_sub_slice
    import serial_sub_pkg::*;
(
    input  logic [NIB_W-1:0] a_nib,
    input  logic [NIB_W-1:0] b_nib,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] full;

    // Widen by one bit so the carry out falls into the top bit
    always_comb begin
        full = {1'b0, a_nib} + {1'b0, ~b_nib} + {{NIB_W{1'b0}}, cin};
        sum  = full[NIB_W-1:0];
        cout = full[NIB_W];
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Nibble-serial a - b controller: accepts an operand pair, subtracts one
// nibble per cycle LSB first, then presents diff/cout/ovf/zero until taken.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NIBS = WIDTH / NIB_W;
    localparam int unsigned CW   = $clog2(NIBS);
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBS - 1);
    localparam int unsigned MSB  = WIDTH - 1;

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_width_check
            $error("serial_sub_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] diff_q;
    logic             cout_q, ovf_q, zero_q;

    logic             hs;
    logic             last_nib;
    logic [NIB_W-1:0] a_nib, b_nib, nib_sum;
    logic             nib_cout;
    logic [WIDTH-1:0] sum_merge;

    assign hs       = in_valid && in_ready;
    assign last_nib = (cnt_q == LAST_CNT);

    // Select the current operand nibbles and splice the new sum nibble into
    // the working sum; constant-index loops keep the slices static.
    always_comb begin
        a_nib     = '0;
        b_nib     = '0;
        sum_merge = sum_q;
        for (int unsigned i = 0; i < NIBS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_nib = a_q[i*NIB_W +: NIB_W];
                b_nib = b_q[i*NIB_W +: NIB_W];
                sum_merge[i*NIB_W +: NIB_W] = nib_sum;
            end
        end
    end

    nibble_sub_slice u_slice (
        .a_nib (a_nib),
        .b_nib (b_nib),
        .cin   (carry_q),
        .sum   (nib_sum),
        .cout  (nib_cout)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = RUN;
            RUN:     if (last_nib) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        res_valid = (state_q == DONE);
    end

    // Datapath: operand capture, serial accumulation, result publication.
    // The working sum lives in sum_q; diff only updates on the last nibble
    // so partial results never appear on the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        a_q     <= a;
                        b_q     <= b;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        carry_q <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q   <= sum_merge;
                    carry_q <= nib_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_nib) begin
                        diff_q <= sum_merge;
                        cout_q <= nib_cout;
                        ovf_q  <= (a_q[MSB] != b_q[MSB]) && (sum_merge[MSB] != a_q[MSB]);
                        zero_q <= (sum_merge == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
